// File: rtl/wb_commit.sv
// -----------------------------------------------------------------------------
// wb_commit -- write-back / commit stage
//
// Purpose:
//   Picks the final write-back value. It is either the ALU result or the load
//   data taken from the data-memory read word, by byte lane, with sign or zero
//   extension. The value is committed to the general register file, where
//   register 0 is hardwired to zero. The block also holds HI/LO and serves the
//   two decode-stage read ports.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : the read ports and hi_o/lo_o return the value being written
//               this cycle (write-first).
//   undefined : reads return the stored value (read-before-write). Decode must
//               then forward from wb_wd.
//
// Ports:
//   cpu_clk_50M      stage clock; state updates on the rising edge
//   cpu_rst_n        asynchronous active-low reset
//   wb_aluop         operation code (load codes LB/LBU/LH/LHU/LW)
//   wb_wa            destination register address
//   wb_wreg          register-file write request
//   wb_whilo         HI/LO write request
//   wb_mreg          1 = result from memory, 0 = result is wb_dreg
//   wb_dreg          ALU result
//   wb_dhilo         {HI,LO} value to write
//   wb_dre           byte-lane read enables (bit i -> bits 8i+7:8i)
//   dm               data-memory read word
//   ra1/ra2, re1/re2 decode read addresses / enables
//   rd1/rd2          decode read data
//   hi_o/lo_o        current HI / LO
//   wb_wd            selected write-back value (for forwarding)
//   wb_commit_v      register-file write occurs this cycle
// -----------------------------------------------------------------------------
`ifndef ALUOP_BUS
`define ALUOP_BUS 7:0
`endif
`ifndef LB
`define LB  8'h90
`endif
`ifndef LBU
`define LBU 8'h91
`endif
`ifndef LH
`define LH  8'h92
`endif
`ifndef LHU
`define LHU 8'h93
`endif
`ifndef LW
`define LW  8'h94
`endif

module wb_commit #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic [`ALUOP_BUS] wb_aluop,
  input  logic [4:0]        wb_wa,
  input  logic              wb_wreg,
  input  logic              wb_whilo,
  input  logic              wb_mreg,
  input  logic [DATA_W-1:0] wb_dreg,
  input  logic [2*DATA_W-1:0] wb_dhilo,
  input  logic [3:0]        wb_dre,
  input  logic [DATA_W-1:0] dm,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic              re1,
  input  logic              re2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] wb_wd,
  output logic              wb_commit_v
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] hi_q, lo_q;

  logic [DATA_W-1:0] sel_wd;
  logic              lane_ok;
  logic              commit;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_byte, is_half, is_word;

  // Lane decode and extension. A half-word lane pattern is legal only for
  // LH/LHU. Any other load code with 0011/1100 is treated as a malformed
  // access and is suppressed.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (wb_dre)
      4'b0001: begin byte_sel = dm[7:0];   is_byte = 1'b1; end
      4'b0010: begin byte_sel = dm[15:8];  is_byte = 1'b1; end
      4'b0100: begin byte_sel = dm[23:16]; is_byte = 1'b1; end
      4'b1000: begin byte_sel = dm[31:24]; is_byte = 1'b1; end
      4'b0011: begin half_sel = dm[15:0];  is_half = 1'b1; end
      4'b1100: begin half_sel = dm[31:16]; is_half = 1'b1; end
      4'b1111: is_word = 1'b1;
      default: ;
    endcase

    sel_wd  = '0;
    lane_ok = 1'b0;
    if (!wb_mreg) begin
      sel_wd  = wb_dreg;
      lane_ok = 1'b1;
    end else if (is_word) begin
      sel_wd  = dm;
      lane_ok = 1'b1;
    end else if (is_byte) begin
      sel_wd  = (wb_aluop == `LB) ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                                  : {{(DATA_W-8){1'b0}}, byte_sel};
      lane_ok = 1'b1;
    end else if (is_half && (wb_aluop == `LH || wb_aluop == `LHU)) begin
      sel_wd  = (wb_aluop == `LH) ? {{(DATA_W-16){half_sel[15]}}, half_sel}
                                  : {{(DATA_W-16){1'b0}}, half_sel};
      lane_ok = 1'b1;
    end
  end

  assign commit = wb_wreg && (wb_wa != 5'd0) && lane_ok;

  // Entry 0 is never written because commit excludes address 0.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (commit) regs_q[wb_wa] <= sel_wd;
      if (wb_whilo) begin
        hi_q <= wb_dhilo[2*DATA_W-1:DATA_W];
        lo_q <= wb_dhilo[DATA_W-1:0];
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [4:0] ra);
    logic [DATA_W-1:0] v;
    v = '0;
    if (re && ra != 5'd0) begin
      v = regs_q[ra];
`ifdef WB_BYPASS_EN
      if (commit && ra == wb_wa) v = sel_wd;
`endif
    end
    return v;
  endfunction

  // Every visible output is held at zero while reset is asserted.
  always_comb begin
    rd1         = '0;
    rd2         = '0;
    hi_o        = '0;
    lo_o        = '0;
    wb_wd       = '0;
    wb_commit_v = 1'b0;
    if (cpu_rst_n) begin
      rd1         = read_port(re1, ra1);
      rd2         = read_port(re2, ra2);
      wb_wd       = sel_wd;
      wb_commit_v = commit;
`ifdef WB_BYPASS_EN
      hi_o = wb_whilo ? wb_dhilo[2*DATA_W-1:DATA_W] : hi_q;
      lo_o = wb_whilo ? wb_dhilo[DATA_W-1:0]        : lo_q;
`else
      hi_o = hi_q;
      lo_o = lo_q;
`endif
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
`timescale 1ns/1ps
`ifndef ALUOP_BUS
`define ALUOP_BUS 7:0
`endif
`ifndef LB
`define LB  8'h90
`endif
`ifndef LBU
`define LBU 8'h91
`endif
`ifndef LH
`define LH  8'h92
`endif
`ifndef LHU
`define LHU 8'h93
`endif
`ifndef LW
`define LW  8'h94
`endif

module tb_wb_commit;

  localparam logic [7:0] OP_ADD = 8'h18;

  logic              cpu_clk_50M = 1'b0;
  logic              cpu_rst_n;
  logic [`ALUOP_BUS] wb_aluop;
  logic [4:0]        wb_wa;
  logic              wb_wreg, wb_whilo, wb_mreg;
  logic [31:0]       wb_dreg;
  logic [63:0]       wb_dhilo;
  logic [3:0]        wb_dre;
  logic [31:0]       dm;
  logic [4:0]        ra1, ra2;
  logic              re1, re2;
  logic [31:0]       rd1, rd2, hi_o, lo_o, wb_wd;
  logic              wb_commit_v;

  int n_vec = 0;
  int n_err = 0;

  wb_commit dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .wb_aluop    (wb_aluop),
    .wb_wa       (wb_wa),
    .wb_wreg     (wb_wreg),
    .wb_whilo    (wb_whilo),
    .wb_mreg     (wb_mreg),
    .wb_dreg     (wb_dreg),
    .wb_dhilo    (wb_dhilo),
    .wb_dre      (wb_dre),
    .dm          (dm),
    .ra1         (ra1),
    .ra2         (ra2),
    .re1         (re1),
    .re2         (re2),
    .rd1         (rd1),
    .rd2         (rd2),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .wb_wd       (wb_wd),
    .wb_commit_v (wb_commit_v)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%08h expected=%08h", n_vec, tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic drive(input logic wreg, input logic [4:0] wa, input logic mreg,
                       input logic [7:0] op, input logic [3:0] dre, input logic [31:0] dreg);
    wb_wreg  = wreg;
    wb_wa    = wa;
    wb_mreg  = mreg;
    wb_aluop = op;
    wb_dre   = dre;
    wb_dreg  = dreg;
    #1;
  endtask

  task automatic idle();
    wb_wreg  = 1'b0;
    wb_whilo = 1'b0;
    wb_mreg  = 1'b0;
    #1;
  endtask

  task automatic read1(input logic [4:0] a, input string tag, input logic [31:0] exp);
    re1 = 1'b1;
    ra1 = a;
    #1;
    check(tag, rd1, exp);
  endtask

  task automatic load(input logic [4:0] wa, input logic [7:0] op, input logic [3:0] dre,
                      input logic [31:0] exp_wd, input logic exp_v, input string tag);
    drive(1'b1, wa, 1'b1, op, dre, 32'h0BAD_0BAD);
    check({tag, "_wd"}, wb_wd, exp_wd);
    check({tag, "_v"}, {31'd0, wb_commit_v}, {31'd0, exp_v});
    tick();
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    wb_aluop  = OP_ADD;
    wb_wa     = 5'd0;
    wb_wreg   = 1'b0;
    wb_whilo  = 1'b0;
    wb_mreg   = 1'b0;
    wb_dreg   = 32'h0;
    wb_dhilo  = 64'h0;
    wb_dre    = 4'b0000;
    dm        = 32'h80FF7F01;
    ra1 = 5'd0; ra2 = 5'd0; re1 = 1'b0; re2 = 1'b0;

    // Hold a write request during reset; outputs must stay at zero.
    #12;
    drive(1'b1, 5'd5, 1'b0, OP_ADD, 4'b0000, 32'h12345678);
    check("rst_commit_v", {31'd0, wb_commit_v}, 32'd0);
    check("rst_wd", wb_wd, 32'h0);
    cpu_rst_n = 1'b1;
    #1;
    check("wr5_commit_v", {31'd0, wb_commit_v}, 32'd1);
    tick();
    idle();
    read1(5'd5, "reg5_written", 32'h12345678);

    // Asynchronous reset clears the array without a clock edge.
    cpu_rst_n = 1'b0;
    #1;
    check("in_rst_rd1", rd1, 32'h0);
    check("in_rst_hi", hi_o, 32'h0);
    check("in_rst_lo", lo_o, 32'h0);
    cpu_rst_n = 1'b1;
    #1;
    read1(5'd5, "reg5_after_rst", 32'h0);
    check("hi_after_rst", hi_o, 32'h0);
    check("lo_after_rst", lo_o, 32'h0);
    check("commit_v_after_rst", {31'd0, wb_commit_v}, 32'd0);

    // ALU write to reg 3, including the same-cycle read.
    tick();
    drive(1'b1, 5'd3, 1'b0, OP_ADD, 4'b0000, 32'hDEADBEEF);
    re2 = 1'b1; ra2 = 5'd3;
    check("alu_wd", wb_wd, 32'hDEADBEEF);
    check("alu_commit_v", {31'd0, wb_commit_v}, 32'd1);
`ifdef WB_BYPASS_EN
    read1(5'd3, "alu_same_cycle", 32'hDEADBEEF);
`else
    read1(5'd3, "alu_same_cycle", 32'h0);
`endif
    tick();
    idle();
    read1(5'd3, "alu_next_rd1", 32'hDEADBEEF);
    check("alu_next_rd2", rd2, 32'hDEADBEEF);

    // Loads from dm = 0x80FF7F01.
    load(5'd10, `LB,  4'b0100, 32'hFFFFFFFF, 1'b1, "lb_b2");
    load(5'd11, `LBU, 4'b1000, 32'h00000080, 1'b1, "lbu_b3");
    load(5'd12, `LB,  4'b0001, 32'h00000001, 1'b1, "lb_b0");
    load(5'd13, `LH,  4'b1100, 32'hFFFF80FF, 1'b1, "lh_hi");
    load(5'd14, `LHU, 4'b0011, 32'h00007F01, 1'b1, "lhu_lo");
    load(5'd15, `LW,  4'b0011, 32'h00000000, 1'b0, "lw_half_bad");
    load(5'd16, `LW,  4'b1111, 32'h80FF7F01, 1'b1, "lw_word");
    load(5'd17, `LW,  4'b0000, 32'h00000000, 1'b0, "lw_none");
    load(5'd18, `LBU, 4'b0010, 32'h0000007F, 1'b1, "lbu_b1");
    idle();
    read1(5'd10, "reg10", 32'hFFFFFFFF);
    read1(5'd11, "reg11", 32'h00000080);
    read1(5'd13, "reg13", 32'hFFFF80FF);
    read1(5'd14, "reg14", 32'h00007F01);
    read1(5'd15, "reg15_suppressed", 32'h0);
    read1(5'd17, "reg17_suppressed", 32'h0);
    read1(5'd18, "reg18", 32'h0000007F);

    // Writes to register 0 never commit.
    drive(1'b1, 5'd0, 1'b0, OP_ADD, 4'b0000, 32'hFFFFFFFF);
    check("r0_commit_v", {31'd0, wb_commit_v}, 32'd0);
    tick();
    idle();
    read1(5'd0, "r0_read", 32'h0);

    // Back-to-back writes to one address: the later one wins.
    drive(1'b1, 5'd9, 1'b0, OP_ADD, 4'b0000, 32'h00000001);
    tick();
    drive(1'b1, 5'd9, 1'b0, OP_ADD, 4'b0000, 32'h00000002);
    tick();
    idle();
    read1(5'd9, "b2b_reg9", 32'h00000002);

    // HI/LO and a register write in the same cycle.
    drive(1'b1, 5'd7, 1'b0, OP_ADD, 4'b0000, 32'h00000055);
    wb_whilo = 1'b1;
    wb_dhilo = 64'h00000001_00000002;
    #1;
`ifdef WB_BYPASS_EN
    check("hilo_same_hi", hi_o, 32'h1);
`else
    check("hilo_same_hi", hi_o, 32'h0);
`endif
    tick();
    idle();
    check("hilo_hi", hi_o, 32'h1);
    check("hilo_lo", lo_o, 32'h2);
    read1(5'd7, "hilo_reg7", 32'h00000055);
    re1 = 1'b0;
    #1;
    check("re1_off", rd1, 32'h0);

    // Reset asserted before the edge discards the pending writes.
    drive(1'b1, 5'd8, 1'b0, OP_ADD, 4'b0000, 32'hCAFEF00D);
    wb_whilo = 1'b1;
    wb_dhilo = 64'hAAAAAAAA_BBBBBBBB;
    #1;
    cpu_rst_n = 1'b0;
    tick();
    idle();
    cpu_rst_n = 1'b1;
    #1;
    read1(5'd8, "midrst_reg8", 32'h0);
    read1(5'd7, "midrst_reg7", 32'h0);
    check("midrst_hi", hi_o, 32'h0);
    check("midrst_lo", lo_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
